// File: rtl/rs_pkg.sv
// Shared GF(2^8) arithmetic, generator polynomial and FSM encoding for the RS(N, N-16) encoder.
package rs_pkg;

   localparam int RS_NPAR = 16;
   localparam int RS_SYM_W = 8;
   localparam logic [8:0] RS_PRIM_POLY = 9'h11D;

   typedef logic [RS_SYM_W-1:0] sym_t;
   typedef logic [RS_NPAR-1:0][RS_SYM_W-1:0] gen_t;
   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

   function automatic sym_t gf_mul_const(input sym_t a, input sym_t b);
      logic [8:0] sh;
      sym_t       p;
      p  = '0;
      sh = {1'b0, a};
      for (int i = 0; i < RS_SYM_W; i++) begin
         if (b[i]) p = p ^ sh[7:0];
         sh = sh << 1;
         if (sh[8]) sh = sh ^ RS_PRIM_POLY;
      end
      return p;
   endfunction

   // g(x) = prod_{i=0..15} (x + alpha^i), built at elaboration; RS_GEN[i] is the x^i coefficient.
   function automatic gen_t rs_gen_calc();
      logic [RS_NPAR:0][RS_SYM_W-1:0] g;
      sym_t root;
      gen_t res;
      g    = '0;
      g[0] = 8'h01;
      root = 8'h01;
      for (int i = 0; i < RS_NPAR; i++) begin
         for (int j = RS_NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul_const(g[j], root);
         g[0] = gf_mul_const(g[0], root);
         root = gf_mul_const(root, 8'h02);
      end
      for (int k = 0; k < RS_NPAR; k++) res[k] = g[k];
      return res;
   endfunction

   localparam gen_t RS_GEN = rs_gen_calc();

endpackage

// File: rtl/rs_gf_mult_const.sv
// Combinational GF(2^8) multiply by a fixed coefficient; reduces to an XOR network.
module rs_gf_mult_const
   import rs_pkg::*;
#(
   parameter sym_t COEF = 8'h01
) (
   input  logic [7:0] a,
   output logic [7:0] y
);

   assign y = gf_mul_const(a, COEF);

endmodule

// File: rtl/rs_encode_top.sv
// Systematic RS encoder, 16 parity symbols: message passes through, then the LFSR remainder is shifted out.
module rs_encode_top
   import rs_pkg::*;
#(
   parameter int N_SYM = 255
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       enable,
   input  logic       startPls,
   input  logic [7:0] dataIn,
   output logic       ready,
   output logic [7:0] dataOut,
   output logic       startOut,
   output logic       parityFlag,
   output logic       doneOut
);

   localparam int         K      = N_SYM - RS_NPAR;
   localparam logic [7:0] K_LAST = 8'(K - 1);
   localparam logic [7:0] N_LAST = 8'(N_SYM - 1);

   state_t     state;
   logic [7:0] cnt;
   sym_t       r     [RS_NPAR];
   sym_t       base  [RS_NPAR];
   sym_t       prod  [RS_NPAR];
   sym_t       r_msg [RS_NPAR];
   sym_t       fb;
   logic       take_start;
   logic       take_data;
   logic       last_msg;

   // A start pulse (IDLE or DATA) restarts the remainder from zero, which also discards an aborted word.
   always_comb begin
      take_start = enable && startPls && (state != PARITY);
      take_data  = enable && !startPls && (state == DATA);
      for (int i = 0; i < RS_NPAR; i++) base[i] = take_start ? '0 : r[i];
      fb       = dataIn ^ base[RS_NPAR-1];
      r_msg[0] = prod[0];
      for (int i = 1; i < RS_NPAR; i++) r_msg[i] = base[i-1] ^ prod[i];
      last_msg = take_start ? (K_LAST == 8'd0) : (cnt == K_LAST);
   end

   for (genvar g = 0; g < RS_NPAR; g++) begin : g_mul
      rs_gf_mult_const #(.COEF(RS_GEN[g])) u_mul (.a(fb), .y(prod[g]));
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         cnt        <= '0;
         for (int i = 0; i < RS_NPAR; i++) r[i] <= '0;
         dataOut    <= '0;
         startOut   <= 1'b0;
         parityFlag <= 1'b0;
         doneOut    <= 1'b0;
         ready      <= 1'b1;
      end else if (enable) begin
         startOut   <= 1'b0;
         parityFlag <= 1'b0;
         doneOut    <= 1'b0;
         if (take_start || take_data) begin
            dataOut  <= dataIn;
            startOut <= take_start;
            r        <= r_msg;
            cnt      <= take_start ? 8'd1 : cnt + 8'd1;
            if (last_msg) begin
               state <= PARITY;
               ready <= 1'b0;
            end else begin
               state <= DATA;
            end
         end else if (state == PARITY) begin
            dataOut    <= r[RS_NPAR-1];
            parityFlag <= 1'b1;
            for (int i = RS_NPAR-1; i > 0; i--) r[i] <= r[i-1];
            r[0] <= '0;
            if (cnt == N_LAST) begin
               doneOut <= 1'b1;
               state   <= IDLE;
               ready   <= 1'b1;
               cnt     <= '0;
            end else begin
               cnt <= cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: doc/rs_encode_top.md
# rs_encode_top

Systematic Reed-Solomon encoder over GF(2^8) with 16 parity symbols (t = 8), the transmit-side counterpart of the RS decoder chain. It accepts a message stream one symbol per enabled clock and forwards each message symbol unchanged. It then appends the 16 parity symbols produced by a 16-stage LFSR, giving a codeword the decoder consumes directly. It sits between the frame packer and the line interface on the transmit path.

## Interface
- N_SYM, default 255: codeword length in symbols; legal range 17..255. Message length K = N_SYM − 16 (shortened codes allowed).
- CLK  in  1  rising-edge clock.
- RESET  in  1  reset; asynchronous, active-high.
- enable  in  1  global clock enable; when low, all state and outputs hold.
- startPls  in  1  marks the first message symbol of a codeword; qualified by enable.
- dataIn  in  8  message symbol; sampled on every enabled cycle while in IDLE+startPls or DATA.
- ready  out  1  high when the block accepts message symbols (IDLE or DATA).
- dataOut  out  8  codeword symbol, registered.
- startOut  out  1  high with codeword symbol 0 on dataOut.
- parityFlag  out  1  high while dataOut carries a parity symbol.
- doneOut  out  1  high with the last parity symbol (codeword symbol N_SYM−1).

## Operation
- Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02. g(x) = ∏_{i=0}^{15}(x − α^i) = x^16 + G[15]x^15 + … + G[0].
- LFSR registers r[0..15]. In the message phase fb = dataIn ^ r[15], r[0] ← fb·G[0], r[i] ← r[i−1] ^ fb·G[i]. In the parity phase r shifts up (r[i] ← r[i−1], r[0] ← 0), and dataOut takes r[15].
- Counter cnt, 8 bits, counts codeword symbol index 0..N_SYM−1.
- FSM:
  - IDLE: ready=1. enable&startPls loads r with the first-symbol update from r=0, sets cnt=1, and goes to DATA. If K=1, it goes straight to PARITY. A symbol without startPls is dropped.
  - DATA: each enabled cycle consumes dataIn and increments cnt. After consuming symbol K−1 it goes to PARITY.
    - startPls in DATA aborts the current codeword: r is restarted from 0 with this symbol and cnt=1. startOut is reasserted and no parity is emitted for the aborted word.
  - PARITY: ready=0. Inputs are ignored, including startPls. It emits 16 symbols r[15] first. After the 16th it returns to IDLE.
- Output of a message symbol = dataIn unchanged. Parity order is highest-degree coefficient first.

## Timing
- Reset values: state IDLE, cnt 0, r all 0, dataOut 0x00, startOut 0, parityFlag 0, doneOut 0, ready 1.
- Latency is 1 enabled cycle. A symbol accepted at enabled cycle t appears on dataOut at t+1.
- Codeword symbol j appears at t0+1+j for j = 0..N_SYM−1, where t0 is the startPls cycle.
  - parityFlag is high for j ≥ K.
  - doneOut is high for j = N_SYM−1 only.
- ready falls at the edge after symbol K−1 is accepted. It rises at the edge that emits the last parity symbol into the output register, so the next startPls can be taken that same cycle. Back-to-back period is N_SYM cycles with 16 idle input slots.
- When enable is low, nothing advances. dataOut, flags, cnt and r hold, and pulses stretch accordingly.
- RESET mid-codeword returns everything to the reset values on the next evaluation. No partial parity is emitted.

## Structure
- Package rs_pkg holds:
  - RS_NPAR = 16 and RS_SYM_W = 8.
  - RS_PRIM_POLY = 9'h11D.
  - Generator coefficient constant array RS_GEN[0:15].
  - Function gf_mul_const.
  - FSM state enum {IDLE, DATA, PARITY}.
- Sub-module rs_gf_mult_const: combinational GF(2^8) multiply by a constant coefficient, instantiated 16×.
- Top-level: FSM, counter, LFSR and output register.

## Test plan
- All-zero message, N_SYM=255 → 255 zero symbols out. startOut at j=0, parityFlag for j=239..254, doneOut at j=254.
- Message all zero except symbol 238 = 0x01 → parity out equals RS_GEN[15], RS_GEN[14], …, RS_GEN[0] in that order.
- 200 random codewords → every output codeword gives all-zero syndromes in the RS decoder and decodes with zero corrections. Message symbols must match the input bit-exactly.
- enable toggled pseudo-randomly at 50% → output sequence identical to the enable=1 run. Flags stay aligned to their symbols.
- startPls at message symbol 100, then a full 239-symbol message → no parity for the aborted word. Second codeword correct. startOut is seen twice.
- RESET asserted during parity symbol 5 → outputs 0 and ready=1 immediately. The next codeword after reset is correct. Codeword with N_SYM=32 → parity matches the software model.
